// File: rtl/fp_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_pkg
// Description : Shared widths, bias function, field-slicing helpers and the
//               packed result record for the pipelined FP multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_mul_pkg;

    localparam int C_DEF_EXP_W  = 7;
    localparam int C_DEF_FRAC_W = 16;
    localparam int C_DEF_W      = 1 + C_DEF_EXP_W + C_DEF_FRAC_W;

    // Exponent bias for a given exponent field width
    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Field slicing on a zero-extended operand of arbitrary field widths
    function automatic logic fp_sign(input logic [63:0] v, input int exp_w, input int frac_w);
        return v[exp_w + frac_w];
    endfunction

    function automatic logic [63:0] fp_exp(input logic [63:0] v, input int exp_w, input int frac_w);
        return (v >> frac_w) & ((64'd1 << exp_w) - 64'd1);
    endfunction

    function automatic logic [63:0] fp_frac(input logic [63:0] v, input int frac_w);
        return v & ((64'd1 << frac_w) - 64'd1);
    endfunction

    // Result record at the default widths
    typedef struct packed {
        logic                    sign;
        logic [C_DEF_EXP_W-1:0]  exp;
        logic [C_DEF_FRAC_W-1:0] frac;
        logic                    overflow;
        logic                    underflow;
    } fp_result_t;

endpackage : fp_mul_pkg
`default_nettype wire

// File: rtl/fp_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_norm_round
// Description : Normalise the raw mantissa product, extract guard/sticky and
//               round. Round-to-nearest-even when FP_MUL_PIPE_ROUND_EN is
//               defined, truncation otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_norm_round #(
    parameter int EXP_W  = 7,
    parameter int FRAC_W = 16
) (
    input  logic [2*FRAC_W+1:0] prod,
    input  logic [EXP_W+1:0]    exp_in,
    output logic [FRAC_W-1:0]   frac,
    output logic [EXP_W+1:0]    exp_out
);

    localparam int              C_PW   = 2 * FRAC_W + 2;
    localparam int              C_EW   = EXP_W + 2;
    localparam logic [C_EW-1:0] C_E_ONE = C_EW'(1);

    logic [FRAC_W-1:0] w_norm_frac;
    logic [C_EW-1:0]   w_exp_norm;

    // Product lies in [1,4): shift down one place when the top bit is set
    always_comb begin
        w_norm_frac = prod[C_PW-3:FRAC_W];
        w_exp_norm  = exp_in;
        if (prod[C_PW-1]) begin
            w_norm_frac = prod[C_PW-2:FRAC_W+1];
            w_exp_norm  = exp_in + C_E_ONE;
        end
    end

`ifdef FP_MUL_PIPE_ROUND_EN
    logic            w_guard;
    logic            w_sticky;
    logic            w_round_up;
    logic [FRAC_W:0] w_frac_sum;

    // Guard and sticky bits depend on which way the product was normalised
    always_comb begin
        w_guard  = prod[FRAC_W-1];
        w_sticky = |prod[FRAC_W-2:0];
        if (prod[C_PW-1]) begin
            w_guard  = prod[FRAC_W];
            w_sticky = |prod[FRAC_W-1:0];
        end
    end

    assign w_round_up = w_guard && (w_sticky || w_norm_frac[0]);
    assign w_frac_sum = {1'b0, w_norm_frac} + {{FRAC_W{1'b0}}, w_round_up};
    // A carry out of the fraction leaves it zero and bumps the exponent
    assign frac       = w_frac_sum[FRAC_W-1:0];
    assign exp_out    = w_frac_sum[FRAC_W] ? (w_exp_norm + C_E_ONE) : w_exp_norm;
`else
    // Bits below the kept fraction only matter for rounding
    logic unused_low_bits;
    assign unused_low_bits = ^prod[FRAC_W-1:0];
    assign frac            = w_norm_frac;
    assign exp_out         = w_exp_norm;
`endif

endmodule : fp_norm_round
`default_nettype wire

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_pipe
// Description : 4-stage pipelined floating-point multiplier with valid/ready
//               flow control, zero handling, overflow saturation and
//               underflow flush. Optional rounding: FP_MUL_PIPE_ROUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W  = C_DEF_EXP_W,
    parameter int FRAC_W = C_DEF_FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   in_a,
    input  logic [EXP_W+FRAC_W:0]   in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_overflow,
    output logic                    out_underflow
);

    localparam int              C_W    = 1 + EXP_W + FRAC_W;
    localparam int              C_PW   = 2 * FRAC_W + 2;
    localparam int              C_EW   = EXP_W + 2;
    localparam int              C_BIAS = bias_of(EXP_W);
    localparam logic [C_EW-1:0] C_E_MAX = C_EW'((1 << EXP_W) - 1);

    logic              w_adv;

    logic              r_s1_valid;
    logic [C_W-1:0]    r_s1_a;
    logic [C_W-1:0]    r_s1_b;

    logic              r_s2_valid;
    logic              r_s2_sign;
    logic              r_s2_zero;
    logic [C_EW-1:0]   r_s2_e;
    logic [C_PW-1:0]   r_s2_prod;

    logic              r_s3_valid;
    logic              r_s3_sign;
    logic              r_s3_zero;
    logic [C_EW-1:0]   r_s3_e;
    logic [FRAC_W-1:0] r_s3_frac;

    logic [EXP_W-1:0]  w_exp_a;
    logic [EXP_W-1:0]  w_exp_b;
    logic [FRAC_W-1:0] w_frac_a;
    logic [FRAC_W-1:0] w_frac_b;
    logic              w_sign;
    logic              w_zero;
    logic [C_EW-1:0]   w_e;
    logic [C_PW-1:0]   w_prod;

    logic [FRAC_W-1:0] w_nr_frac;
    logic [C_EW-1:0]   w_nr_e;

    logic              w_sel_ovf;
    logic              w_sel_unf;
    logic [EXP_W-1:0]  w_sel_exp;
    logic [FRAC_W-1:0] w_sel_frac;

    // Whole pipeline advances unless a presented result is being held
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Operand field extraction and S2 arithmetic (signed exponent, no wrap)
    assign w_exp_a  = EXP_W'(fp_exp(64'(r_s1_a), EXP_W, FRAC_W));
    assign w_exp_b  = EXP_W'(fp_exp(64'(r_s1_b), EXP_W, FRAC_W));
    assign w_frac_a = FRAC_W'(fp_frac(64'(r_s1_a), FRAC_W));
    assign w_frac_b = FRAC_W'(fp_frac(64'(r_s1_b), FRAC_W));
    assign w_sign   = fp_sign(64'(r_s1_a), EXP_W, FRAC_W) ^ fp_sign(64'(r_s1_b), EXP_W, FRAC_W);
    assign w_zero   = (w_exp_a == '0) || (w_exp_b == '0);
    assign w_e      = {2'b00, w_exp_a} + {2'b00, w_exp_b} - C_EW'(C_BIAS);
    assign w_prod   = C_PW'({1'b1, w_frac_a}) * C_PW'({1'b1, w_frac_b});

    fp_norm_round #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_norm_round (
        .prod    (r_s2_prod),
        .exp_in  (r_s2_e),
        .frac    (w_nr_frac),
        .exp_out (w_nr_e)
    );

    // Special-case select: zero beats overflow beats underflow
    always_comb begin
        w_sel_ovf  = 1'b0;
        w_sel_unf  = 1'b0;
        w_sel_exp  = '0;
        w_sel_frac = '0;
        if (!r_s3_zero) begin
            if (!r_s3_e[C_EW-1] && (r_s3_e > C_E_MAX)) begin
                w_sel_ovf  = 1'b1;
                w_sel_exp  = '1;
                w_sel_frac = '1;
            end else if (r_s3_e[C_EW-1] || (r_s3_e == '0)) begin
                w_sel_unf  = 1'b1;
            end else begin
                w_sel_exp  = r_s3_e[EXP_W-1:0];
                w_sel_frac = r_s3_frac;
            end
        end
    end

    // Stage registers S1..S4, all shifting together on advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_s3_valid    <= 1'b0;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid    <= in_valid;
            r_s1_a        <= in_a;
            r_s1_b        <= in_b;
            r_s2_valid    <= r_s1_valid;
            r_s2_sign     <= w_sign;
            r_s2_zero     <= w_zero;
            r_s2_e        <= w_e;
            r_s2_prod     <= w_prod;
            r_s3_valid    <= r_s2_valid;
            r_s3_sign     <= r_s2_sign;
            r_s3_zero     <= r_s2_zero;
            r_s3_e        <= w_nr_e;
            r_s3_frac     <= w_nr_frac;
            out_valid     <= r_s3_valid;
            out_result    <= {r_s3_sign, w_sel_exp, w_sel_frac};
            out_overflow  <= r_s3_valid && w_sel_ovf;
            out_underflow <= r_s3_valid && w_sel_unf;
        end
    end

endmodule : fp_mul_pipe
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_pipe
// Description : Scoreboard bench for fp_mul_pipe with a real-arithmetic
//               reference model, directed corner cases, backpressure and
//               mid-flight reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_pipe;
    import fp_mul_pkg::*;

    localparam int EW   = 7;
    localparam int FW   = 16;
    localparam int W    = 1 + EW + FW;
    localparam int BIAS = 63;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
        logic         unf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_overflow;
    logic         out_underflow;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic rand_ready = 1'b0;

    fp_mul_pipe #(.EXP_W(EW), .FRAC_W(FW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact real-valued significand product, then the result rules
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        int   ea, eb, e, fi;
        real  p, fr, rem;
        logic s;
        s  = a[W-1] ^ b[W-1];
        ea = int'(a[W-2:FW]);
        eb = int'(b[W-2:FW]);
        r.ovf = 1'b0;
        r.unf = 1'b0;
        r.res = {s, {(W-1){1'b0}}};
        if (ea == 0 || eb == 0) return r;
        p = (1.0 + real'(int'(a[FW-1:0])) / 65536.0) * (1.0 + real'(int'(b[FW-1:0])) / 65536.0);
        e = ea + eb - BIAS;
        if (p >= 2.0) begin
            p = p / 2.0;
            e++;
        end
        fr  = (p - 1.0) * 65536.0;
        fi  = $rtoi(fr);
        rem = fr - real'(fi);
`ifdef FP_MUL_PIPE_ROUND_EN
        if (rem > 0.5 || (rem == 0.5 && (fi % 2) == 1)) fi++;
        if (fi == 65536) begin
            fi = 0;
            e++;
        end
`else
        if (rem < 0.0) fi = 0;
`endif
        if (e > 127) begin
            r.res = {s, 7'h7F, 16'hFFFF};
            r.ovf = 1'b1;
        end else if (e <= 0) begin
            r.unf = 1'b1;
        end else begin
            r.res = {s, 7'(e), 16'(fi)};
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op();
        int   sel;
        logic [EW-1:0] ex;
        sel = $urandom_range(0, 9);
        if (sel == 0)      ex = '0;
        else if (sel <= 3) ex = EW'($urandom_range(1, 127));
        else if (sel == 4) ex = ($urandom_range(0, 1) == 1) ? EW'($urandom_range(120, 127)) : EW'($urandom_range(1, 8));
        else               ex = EW'($urandom_range(40, 90));
        return {1'($urandom_range(0, 1)), ex, 16'($urandom_range(0, 65535))};
    endfunction

    // Present one operand pair (starting at a falling edge) until accepted
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        #1;
        while (!in_ready && budget < 1000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready=0 required=in_ready=1");
        end else begin
            acc_cyc = cyc;
            sb_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb_q.size() != 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: every presented result must match the oldest expectation
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h required=none", out_result);
            end else begin
                check("result", 64'({out_result, out_overflow, out_underflow}), 64'(sb_q[0]));
                check("flags_exclusive", 64'(out_overflow && out_underflow), 64'd0);
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    popped++;
                end
            end
        end
    end

    // Random sink readiness when enabled
    initial forever begin
        @(negedge clk);
        if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        int   base;
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_result", 64'(out_result), 64'd0);
        check("reset_flags", 64'({out_overflow, out_underflow}), 64'd0);
        @(negedge clk);

        // Basic with latency measurement
        drive(24'h3F_8000, 24'h3F_8000, '{res: 24'h40_2000, ovf: 1'b0, unf: 1'b0});
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            #3;
            if (out_valid) begin
                lat = cyc - acc_cyc;
                break;
            end
            @(negedge clk);
        end
        check("latency", 64'(lat), 64'd4);
        drain();

        // Sign, zero, overflow, underflow, rounding tie
        drive(24'hBF_0000, 24'h40_0000, '{res: 24'hC0_0000, ovf: 1'b0, unf: 1'b0});
        drive(24'h00_1234, 24'h45_0000, '{res: 24'h00_0000, ovf: 1'b0, unf: 1'b0});
        drive(24'h7F_0000, 24'h7F_0000, '{res: 24'h7F_FFFF, ovf: 1'b1, unf: 1'b0});
        drive(24'h01_0000, 24'h01_0000, '{res: 24'h00_0000, ovf: 1'b0, unf: 1'b1});
`ifdef FP_MUL_PIPE_ROUND_EN
        drive(24'h3F_0001, 24'h3F_8000, '{res: 24'h3F_8002, ovf: 1'b0, unf: 1'b0});
`else
        drive(24'h3F_0001, 24'h3F_8000, '{res: 24'h3F_8001, ovf: 1'b0, unf: 1'b0});
`endif
        drain();

        // Backpressure: 8 back-to-back with a 3-cycle sink stall mid-stream
        base = popped;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a = rand_op();
                    b = rand_op();
                    drive(a, b, model(a, b));
                end
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) begin
                    #1;
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("backpressure_count", 64'(popped - base), 64'd8);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            a = rand_op();
            b = rand_op();
            drive(a, b, model(a, b));
        end
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #2;
            check("post_reset_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        drive(24'h3F_8000, 24'h3F_8000, '{res: 24'h40_2000, ovf: 1'b0, unf: 1'b0});
        drive(24'hBF_0000, 24'h40_0000, '{res: 24'hC0_0000, ovf: 1'b0, unf: 1'b0});
        drain();

        // Randomised traffic with random gaps and random sink readiness
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            a = rand_op();
            b = rand_op();
            drive(a, b, model(a, b));
        end
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fp_mul_pipe
`default_nettype wire
